// File: rtl/ava_scanout_if.sv
// Bus bundle between the AVA scanout engine and its VRAM, palette RAM and pixel FIFO.
// Pixel handshake: a pixel transfers on a cycle where pixel_valid & pixel_ready; once valid rises, valid and data hold until that transfer.
interface ava_scanout_if #(
  parameter int VRAM_ADDR_WIDTH = 17,
  parameter int PRAM_ADDR_WIDTH = 8
);
  logic [VRAM_ADDR_WIDTH-1:0] vram_a;
  logic                       vram_en;
  logic [31:0]                vram_do;
  logic [PRAM_ADDR_WIDTH-1:0] pram_a;
  logic                       pram_en;
  logic [31:0]                pram_do;
  logic [23:0]                pixel_data;
  logic                       pixel_valid;
  logic                       pixel_ready;
  logic                       frame_done;
  logic                       line_irq;

  modport master (
    output vram_a, vram_en, input vram_do,
    output pram_a, pram_en, input pram_do,
    output pixel_data, pixel_valid, input pixel_ready,
    output frame_done, line_irq
  );

  modport slave (
    input vram_a, vram_en, output vram_do,
    input pram_a, pram_en, output pram_do,
    input pixel_data, pixel_valid, output pixel_ready,
    input frame_done, line_irq
  );
endinterface

// File: rtl/ava_scanout_engine.sv
// AVA scanout engine: raster walk, VRAM fetch, pixel unpack, palette lookup, 24-bit RGB out under backpressure.
// Optional line-compare interrupt enabled by defining AVA_SCANOUT_LINE_IRQ_EN.
module ava_scanout_engine #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int VRAM_ADDR_WIDTH = 17,
  parameter int PRAM_ADDR_WIDTH = 8,
  parameter int MAX_SCALE_LOG2  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 cfg_bpp_log2,
  input  logic [1:0]                 cfg_scale_log2,
  input  logic [VRAM_ADDR_WIDTH-1:0] cfg_base_addr,
`ifdef AVA_SCANOUT_LINE_IRQ_EN
  input  logic [$clog2(V_RES)-1:0]   cfg_line_cmp,
`endif
  ava_scanout_if.master              bus
);
  localparam int XW  = $clog2(H_RES);
  localparam int YW  = $clog2(V_RES);
  localparam int YW1 = YW + 1;
  localparam int SW  = $clog2(H_RES * V_RES + 1);

  // S0 raster state and per-frame shadow configuration
  logic [XW-1:0]              r_x;
  logic [YW-1:0]              r_y;
  logic [SW-1:0]              r_line_base;
  logic                       r_sh_direct;
  logic [1:0]                 r_sh_bpp;
  logic [1:0]                 r_sh_scale;
  logic [VRAM_ADDR_WIDTH-1:0] r_sh_base;

  // S1 / S2 / S3 pipeline registers
  logic        r_s1_valid, r_s1_direct, r_s1_last;
  logic [1:0]  r_s1_bpp;
  logic [4:0]  r_s1_shift;
  logic        r_s2_valid, r_s2_direct, r_s2_last;
  logic [23:0] r_s2_rgb;
  logic        r_pix_valid, r_pix_last;
  logic [23:0] r_pix_data;

  logic                       w_advance, w_issue, w_first, w_x_last, w_y_last;
  logic                       w_cfg_direct, w_direct;
  logic [1:0]                 w_cfg_scale, w_scale, w_bpp;
  logic [VRAM_ADDR_WIDTH-1:0] w_base;
  logic [SW-1:0]              w_sx, w_src, w_word_off, w_line_step;
  logic [4:0]                 w_field, w_shift;
  logic [YW:0]                w_y_inc, w_smask;
  logic [7:0]                 w_s1_word, w_idx8;
  logic [23:0]                w_s2_pix;
  logic                       w_unused_bits;

  assign w_advance = ~(r_pix_valid & ~bus.pixel_ready);
  assign w_issue   = w_advance & ~reset;

  // Pixel (0,0) uses the live config; every later pixel of the frame uses the copy taken then.
  assign w_first      = (r_x == '0) && (r_y == '0);
  assign w_cfg_direct = (cfg_bpp_log2 > 3'd3);
  assign w_cfg_scale  = (cfg_scale_log2 > 2'(MAX_SCALE_LOG2)) ? 2'(MAX_SCALE_LOG2) : cfg_scale_log2;
  assign w_direct     = w_first ? w_cfg_direct        : r_sh_direct;
  assign w_bpp        = w_first ? cfg_bpp_log2[1:0]   : r_sh_bpp;
  assign w_scale      = w_first ? w_cfg_scale         : r_sh_scale;
  assign w_base       = w_first ? cfg_base_addr       : r_sh_base;

  assign w_x_last    = (r_x == XW'(H_RES - 1));
  assign w_y_last    = (r_y == YW'(V_RES - 1));
  assign w_y_inc     = {1'b0, r_y} + YW1'(1);
  assign w_smask     = (YW1'(1) << w_scale) - YW1'(1);
  assign w_line_step = SW'(H_RES) >> w_scale;

  assign w_sx       = SW'(r_x) >> w_scale;
  assign w_src      = r_line_base + w_sx;
  assign w_word_off = w_direct ? w_src : (w_src >> (3'd5 - {1'b0, w_bpp}));
  assign w_field    = w_src[4:0] & (5'h1F >> w_bpp);
  assign w_shift    = w_field << w_bpp;

  assign bus.vram_a  = w_base + VRAM_ADDR_WIDTH'(w_word_off);
  assign bus.vram_en = w_issue;
  assign bus.pram_en = w_issue;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_base <= '0;
      r_sh_direct <= 1'b0;
      r_sh_bpp    <= '0;
      r_sh_scale  <= '0;
      r_sh_base   <= '0;
    end else if (w_advance) begin
      if (w_first) begin
        r_sh_direct <= w_cfg_direct;
        r_sh_bpp    <= cfg_bpp_log2[1:0];
        r_sh_scale  <= w_cfg_scale;
        r_sh_base   <= cfg_base_addr;
      end
      if (w_x_last) begin
        r_x <= '0;
        if (w_y_last) begin
          r_y         <= '0;
          r_line_base <= '0;
        end else begin
          r_y <= w_y_inc[YW-1:0];
          // Step to the next source row only once every 2^scale output lines.
          if ((w_y_inc & w_smask) == '0)
            r_line_base <= r_line_base + w_line_step;
        end
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // S1: pick the field out of the fetched word; it becomes the palette address.
  assign w_s1_word = 8'(bus.vram_do >> r_s1_shift);

  always_comb begin
    w_idx8 = 8'h00;
    case (r_s1_bpp)
      2'd0:    w_idx8 = {7'b0, w_s1_word[0]};
      2'd1:    w_idx8 = {6'b0, w_s1_word[1:0]};
      2'd2:    w_idx8 = {4'b0, w_s1_word[3:0]};
      default: w_idx8 = w_s1_word;
    endcase
  end

  assign bus.pram_a = r_s1_direct ? '0 : PRAM_ADDR_WIDTH'(w_idx8);

  // Direct pixels ride a register through S2 so both paths share one latency.
  assign w_s2_pix = r_s2_direct ? r_s2_rgb : bus.pram_do[23:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_direct <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_bpp    <= '0;
      r_s1_shift  <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_direct <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s2_rgb    <= '0;
      r_pix_valid <= 1'b0;
      r_pix_last  <= 1'b0;
      r_pix_data  <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= 1'b1;
      r_s1_direct <= w_direct;
      r_s1_last   <= w_x_last & w_y_last;
      r_s1_bpp    <= w_bpp;
      r_s1_shift  <= w_shift;
      r_s2_valid  <= r_s1_valid;
      r_s2_direct <= r_s1_direct;
      r_s2_last   <= r_s1_last;
      r_s2_rgb    <= bus.vram_do[23:0];
      r_pix_valid <= r_s2_valid;
      r_pix_last  <= r_s2_last;
      r_pix_data  <= w_s2_pix;
    end
  end

  assign bus.pixel_valid = r_pix_valid;
  assign bus.pixel_data  = r_pix_data;
  assign bus.frame_done  = ~reset & r_pix_valid & bus.pixel_ready & r_pix_last;
  assign w_unused_bits   = ^bus.pram_do[31:24];

`ifdef AVA_SCANOUT_LINE_IRQ_EN
  logic r_s1_irq, r_s2_irq, r_pix_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_irq  <= 1'b0;
      r_s2_irq  <= 1'b0;
      r_pix_irq <= 1'b0;
    end else if (w_advance) begin
      r_s1_irq  <= w_x_last && (r_y == cfg_line_cmp);
      r_s2_irq  <= r_s1_irq;
      r_pix_irq <= r_s2_irq;
    end
  end

  assign bus.line_irq = ~reset & r_pix_valid & bus.pixel_ready & r_pix_irq;
`else
  assign bus.line_irq = 1'b0;
`endif
endmodule

// File: tb/tb_ava_scanout_engine.sv
// Bench for ava_scanout_engine: random frame configs with backpressure, pixel and address scoreboards, mid-frame reset.
module tb_ava_scanout_engine;
  localparam int H    = 64;
  localparam int V    = 16;
  localparam int VAW  = 10;
  localparam int PAW  = 8;
  localparam int MSL  = 2;
  localparam int NPIX = H * V;
  localparam int NF   = 7;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [2:0]     cfg_bpp_log2 = '0;
  logic [1:0]     cfg_scale_log2 = '0;
  logic [VAW-1:0] cfg_base_addr = '0;
`ifdef AVA_SCANOUT_LINE_IRQ_EN
  localparam int LINE_CMP = 10;
  logic [$clog2(V)-1:0] cfg_line_cmp = 4'd10;
`endif

  ava_scanout_if #(.VRAM_ADDR_WIDTH(VAW), .PRAM_ADDR_WIDTH(PAW)) bus();

  ava_scanout_engine #(
    .H_RES(H), .V_RES(V), .VRAM_ADDR_WIDTH(VAW), .PRAM_ADDR_WIDTH(PAW), .MAX_SCALE_LOG2(MSL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_bpp_log2(cfg_bpp_log2),
    .cfg_scale_log2(cfg_scale_log2),
    .cfg_base_addr(cfg_base_addr),
`ifdef AVA_SCANOUT_LINE_IRQ_EN
    .cfg_line_cmp(cfg_line_cmp),
`endif
    .bus(bus)
  );

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  logic [31:0] vram_mem [0:(1<<VAW)-1];
  logic [31:0] pram_mem [0:(1<<PAW)-1];

  always @(posedge clk) begin
    if (bus.vram_en) bus.vram_do <= vram_mem[bus.vram_a];
    if (bus.pram_en) bus.pram_do <= pram_mem[bus.pram_a];
  end

  // ---------------- scoreboard state ----------------
  logic [25:0]    exp_q[$];
  logic [VAW-1:0] addr_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int frame_idx = 0;
  int acc_in_frame = 0;
  bit abort = 0;
  bit stall_en = 0;
  int force_low = 0;
  int c_bpp[NF+1];
  int c_sc[NF+1];
  int c_base[NF+1];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: each output pixel maps to source pixel (y>>s)*(H>>s)+(x>>s).
  task automatic push_frame(int bpp, int sc, int base);
    int s, bits, ppw, src, addr, k, idx;
    bit direct, last, irq;
    logic [31:0] w;
    logic [23:0] rgb;
    direct = (bpp > 3);
    s = (sc > MSL) ? MSL : sc;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        src = (y >> s) * (H >> s) + (x >> s);
        if (direct) begin
          addr = (base + src) % (1 << VAW);
          w = vram_mem[addr];
          rgb = w[23:0];
        end else begin
          bits = 1 << bpp;
          ppw = 32 / bits;
          addr = (base + src / ppw) % (1 << VAW);
          k = src % ppw;
          w = vram_mem[addr] >> (k * bits);
          idx = int'(w & ((32'd1 << bits) - 32'd1));
          w = pram_mem[idx % (1 << PAW)];
          rgb = w[23:0];
        end
        last = (x == H - 1) && (y == V - 1);
        irq = 1'b0;
`ifdef AVA_SCANOUT_LINE_IRQ_EN
        irq = (x == H - 1) && (y == LINE_CMP);
`endif
        exp_q.push_back({irq, last, rgb});
        addr_q.push_back(VAW'(addr));
      end
    end
  endtask

  task automatic apply_cfg(int i);
    cfg_bpp_log2   = 3'(c_bpp[i]);
    cfg_scale_log2 = 2'(c_sc[i]);
    cfg_base_addr  = VAW'(c_base[i]);
  endtask

  task automatic wait_acc(int f, int cnt);
    int t = 0;
    while (!abort && !(frame_idx > f || (frame_idx == f && acc_in_frame >= cnt))) begin
      @(negedge clk);
      #2;
      t++;
      if (t > 20000) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout: frame %0d pixel %0d not reached", f, cnt);
        abort = 1;
      end
    end
  endtask

  task automatic measure_latency();
    int lat = 0;
    while (!bus.pixel_valid && lat < 20) begin
      @(negedge clk);
      if (!bus.pixel_valid) lat++;
    end
    check("first_pixel_latency", 32'(lat), 32'd3);
  endtask

  // ---------------- backpressure driver ----------------
  initial begin
    bus.pixel_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_low > 0) begin
        bus.pixel_ready = 1'b0;
        force_low--;
      end else if (stall_en) begin
        bus.pixel_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.pixel_ready = 1'b1;
      end
    end
  end

  // ---------------- monitors ----------------
  logic [25:0] mon_e;
  bit          prev_hold = 0;
  logic [23:0] prev_data;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("valid_held", 32'(bus.pixel_valid), 32'd1);
        check("data_held", 32'(bus.pixel_data), 32'(prev_data));
      end
      if (bus.pixel_valid && bus.pixel_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pixel: got %h with empty expected queue", bus.pixel_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("pixel", 32'(bus.pixel_data), 32'(mon_e[23:0]));
          check("frame_done", 32'(bus.frame_done), 32'(mon_e[24]));
          check("line_irq", 32'(bus.line_irq), 32'(mon_e[25]));
          if (mon_e[24]) begin
            frame_idx++;
            acc_in_frame = 0;
          end else begin
            acc_in_frame++;
          end
        end
      end else begin
        check("frame_done_idle", 32'(bus.frame_done), 32'd0);
        check("line_irq_idle", 32'(bus.line_irq), 32'd0);
      end
      prev_hold = bus.pixel_valid && !bus.pixel_ready;
      prev_data = bus.pixel_data;
    end
  end

  always @(negedge clk) begin
    if (!reset && bus.vram_en) begin
      if (addr_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_fetch: vram_a %h with empty address queue", bus.vram_a);
      end else begin
        check("vram_a", 32'(bus.vram_a), 32'(addr_q.pop_front()));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < (1 << VAW); i++) vram_mem[i] = $urandom();
    for (int i = 0; i < (1 << PAW); i++) pram_mem[i] = {8'($urandom_range(0, 255)), 24'(i * 32'h010101)};
    vram_mem[0] = 32'h04030201;
    vram_mem[1] = 32'h00000005;
    for (int n = 0; n < 512; n++) vram_mem[512 + n] = 32'(n);

    c_bpp[0] = 3; c_sc[0] = 0; c_base[0] = 0;
    c_bpp[1] = 0; c_sc[1] = 0; c_base[1] = 1;
    c_bpp[2] = 5; c_sc[2] = 1; c_base[2] = 512;
    c_bpp[3] = 2; c_sc[3] = 3; c_base[3] = 1000;
    c_bpp[4] = 7; c_sc[4] = 2; c_base[4] = 1020;
    for (int i = 5; i <= NF; i++) begin
      c_bpp[i]  = $urandom_range(0, 7);
      c_sc[i]   = $urandom_range(0, 3);
      c_base[i] = $urandom_range(0, (1 << VAW) - 1);
    end

    apply_cfg(0);
    push_frame(c_bpp[0], c_sc[0], c_base[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
    check("rst_pixel_data", 32'(bus.pixel_data), 32'd0);
    check("rst_vram_en", 32'(bus.vram_en), 32'd0);
    check("rst_pram_en", 32'(bus.pram_en), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_line_irq", 32'(bus.line_irq), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    measure_latency();

    wait_acc(0, 20);
    force_low = 5;

    for (int f = 0; f < NF; f++) begin
      if (!abort) begin
        wait_acc(f, NPIX / 2);
        stall_en = (f < NF - 1);
        apply_cfg(f + 1);
        push_frame(c_bpp[f + 1], c_sc[f + 1], c_base[f + 1]);
      end
    end

    // Mid-frame reset around pixel (40,5) of the last frame, then restart from (0,0).
    if (!abort) begin
      wait_acc(NF, 5 * H + 41);
      if (!abort) begin
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rstmid_vram_en", 32'(bus.vram_en), 32'd0);
        check("rstmid_pram_en", 32'(bus.pram_en), 32'd0);
        check("rstmid_frame_done", 32'(bus.frame_done), 32'd0);
        #2;
        exp_q.delete();
        addr_q.delete();
        frame_idx = 0;
        acc_in_frame = 0;
        push_frame(c_bpp[NF], c_sc[NF], c_base[NF]);
        @(negedge clk);
        check("rstmid_pixel_valid", 32'(bus.pixel_valid), 32'd0);
        check("rstmid_pixel_data", 32'(bus.pixel_data), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        measure_latency();
        wait_acc(0, 2 * H + 5);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
